dsp_mac_sequencer: RTL and testbench
====================================

# dsp_mac_sequencer

Control sequencer that drives the OPMODE and clock-enable inputs of one DSP slice to run an N-tap multiply-accumulate, such as a FIR dot product. Operand delivery is tracked with a per-cycle token pipeline so input stalls become bubbles, not corrupted sums. The block sits beside the slice and owns OPMODE, CECTRL, CEIN, CEM and CEP, with the slice's OPMODE register enabled. A one-cycle DONE marks a valid P output.

## Interface
Parameters:
- TAPW, 8: width of NTAPS and the tap counter.
- PIPE_LAT, 2: clock edges from the operand-accept edge to the P-register capture edge. Legal range is 2..8.

Ports:
- CLK, in, 1: clock, rising edge.
- RSTN, in, 1: reset, asynchronous, active-low.
- START, in, 1: begin a job. Sampled only in IDLE.
- NTAPS, in, TAPW: tap count, latched on START.
- SYMM, in, 1: pre-adder enable for symmetric FIR, latched on START.
- SAMPLE_VLD, in, 1: operands are valid at the slice A/B/D inputs this cycle.
- SAMPLE_RDY, out, 1: the sequencer accepts operands. A transfer occurs when VLD&RDY.
- OPMODE, out, 7: OPMODE value for the slice.
- CECTRL, out, 1: enable for the slice OPMODE register.
- CEIN, out, 1: A/B/D register enable.
- CEM, out, 1: M register enable.
- CEP, out, 1: P register enable.
- BUSY, out, 1: a job is in progress.
- DONE, out, 1: one-cycle pulse; P holds the final sum.
- START_ERR, out, 1: one-cycle pulse when START arrives with NTAPS==0.

## Operation
- States:
  - IDLE
  - ISSUE: accepting operands.
  - DRAIN: waiting for in-flight tokens.
  - FIN: DONE cycle.
- Reset value of every output is 0, including OPMODE=7'b0. State resets to IDLE and all tokens clear.
- IDLE:
  - START with NTAPS!=0: latch NTAPS and SYMM, set remaining count to NTAPS, go to ISSUE.
  - START with NTAPS==0: pulse START_ERR and stay in IDLE.
- ISSUE:
  - SAMPLE_RDY=1.
  - Each transfer pushes a token {valid=1, first=(tap is first)} into the delay line and decrements the count.
  - A cycle without a transfer pushes {valid=0}.
  - On the transfer of the last tap, go to DRAIN.
- DRAIN: SAMPLE_RDY=0. Push {valid=0} each cycle. Go to FIN on the cycle the last valid token reaches the P stage.
- FIN: DONE=1, BUSY=0, then IDLE. A START in FIN is ignored.
- BUSY=1 in ISSUE and DRAIN.
- CEIN=CEM=1 while BUSY. Bubbles are tolerated because CEP gates P.
- OPMODE codes:
  - ACC = X=M, Z=P: 7'b0001001.
  - FIRST = X=M, Z=0: 7'b0000001.
  - Bit 4 = latched SYMM in both codes.
  - Bits 5 and 6 are always 0.
- Between tokens, OPMODE holds its last value and CECTRL=0.

## Timing
- For a token accepted at edge t:
  - OPMODE and CECTRL=1 are driven during the cycle ending at edge t+PIPE_LAT-1, which loads the slice OPMODE register.
  - CEP=1 during the cycle ending at edge t+PIPE_LAT.
- DONE is asserted in the cycle after the last CEP edge. Minimum job latency is NTAPS+PIPE_LAT+1 cycles from START to DONE with no stalls.
- Back-to-back jobs are allowed. START may be asserted in the first IDLE cycle after FIN.
- RSTN assertion mid-job aborts immediately: all outputs go to 0 and the tokens are lost.
- The tap counter is TAPW bits wide. NTAPS=2^TAPW-1 is the largest legal job.

## Configuration
- DSP_SEQ_ROUND_EN defined: FIRST becomes X=M, Z=C (7'b0001101, plus the SYMM bit), so the sum starts from the rounding constant held on the slice C input.
- DSP_SEQ_ROUND_EN undefined: FIRST is Z=0 as specified above.

## Structure
- The shared package holds:
  - State enum.
  - OPMODE field constants: X_ZERO, X_M, X_P, X_DAB, Z_ZERO, Z_PCIN, Z_P, Z_C, PREADD_BIT.
  - Token struct.
- One sub-module, dsp_seq_token_pipe: a parameterised PIPE_LAT-deep shift register of tokens with early (depth-1) and P-stage taps.

## Test plan
- NTAPS=4, SYMM=0, VLD held high, A*B=1 per tap: OPMODE 0000001 then 0001001×3, four CEP pulses, DONE at cycle 7 after START, P=4.
- NTAPS=3 with VLD low for 2 cycles between taps 1 and 2: CEP pulses keep the same gaps, DONE is delayed by 2 cycles, P equals the 3-tap sum.
- START with NTAPS=0: START_ERR pulse, BUSY stays 0, no CE activity.
- RSTN low during DRAIN of an 8-tap job: all outputs 0 asynchronously; a new START then runs a clean job with correct P.
- SYMM=1, NTAPS=2: OPMODE bit 4 is set on both codes.
- With DSP_SEQ_ROUND_EN, C=0x40, NTAPS=1, A*B=5: first OPMODE is 0001101 and P=0x45.

Source files
------------

// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and OPMODE field encodings for the DSP MAC sequencer.
// DSP_SEQ_ROUND_EN selects Z=C (rounding constant) instead of Z=0 for the first tap.
package dsp_mac_sequencer_pkg;

  localparam int unsigned OPMODE_W   = 7;
  localparam int unsigned PREADD_BIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // X multiplexer select, OPMODE[1:0]
  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] X_P    = 2'b10;
  localparam logic [1:0] X_DAB  = 2'b11;

  // Z multiplexer select, OPMODE[3:2]
  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_PCIN = 2'b01;
  localparam logic [1:0] Z_P    = 2'b10;
  localparam logic [1:0] Z_C    = 2'b11;

`ifdef DSP_SEQ_ROUND_EN
  localparam logic [1:0] Z_FIRST = Z_C;
`else
  localparam logic [1:0] Z_FIRST = Z_ZERO;
`endif

  // One entry per accepted cycle; last marks the final tap of a job.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } token_t;

  function automatic logic [OPMODE_W-1:0] opmode_code(input logic first, input logic symm);
    logic [OPMODE_W-1:0] code;
    code             = '0;
    code[1:0]        = X_M;
    code[3:2]        = first ? Z_FIRST : Z_P;
    code[PREADD_BIT] = symm;
    return code;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_token.sv
// Token delay line: push at the accept edge, early tap loads OPMODE, last stage feeds CEP.
module dsp_seq_token_pipe
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  token_t push_tok,
  output token_t early_tok_c,
  output token_t p_tok
);

  localparam int unsigned DEPTH = PIPE_LAT - 1;

  token_t stage_q [DEPTH];
  token_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = push_tok;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // With the shortest latency the OPMODE load coincides with the accept edge.
  generate
    if (PIPE_LAT == 2) begin : g_early_direct
      assign early_tok_c = push_tok;
    end else begin : g_early_stage
      assign early_tok_c = stage_q[PIPE_LAT-3];
    end
  endgenerate

  assign p_tok = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// OPMODE / clock-enable sequencer for an N-tap MAC on one DSP slice.
// Build option DSP_SEQ_ROUND_EN: first tap adds the slice C input (rounding constant).
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int unsigned TAPW     = 8,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                START,
  input  logic [TAPW-1:0]     NTAPS,
  input  logic                SYMM,
  input  logic                SAMPLE_VLD,
  output logic                SAMPLE_RDY,
  output logic [OPMODE_W-1:0] OPMODE,
  output logic                CECTRL,
  output logic                CEIN,
  output logic                CEM,
  output logic                CEP,
  output logic                BUSY,
  output logic                DONE,
  output logic                START_ERR
);

  state_e                state_q, state_d;
  logic [TAPW-1:0]       ntaps_q, ntaps_d;
  logic [TAPW-1:0]       rem_q, rem_d;
  logic                  symm_q, symm_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  start_err_q, start_err_d;
  logic [OPMODE_W-1:0]   opmode_q, opmode_d;
  logic                  cectrl_q, cectrl_d;
  logic                  cep_q, cep_d;
  logic                  p_last_q, p_last_d;

  logic   xfer_c;
  token_t push_tok;
  token_t early_tok_c;
  token_t p_tok;

  dsp_seq_token_pipe #(
    .PIPE_LAT (PIPE_LAT)
  ) u_token_pipe (
    .clk         (CLK),
    .rst_n       (RSTN),
    .push_tok    (push_tok),
    .early_tok_c (early_tok_c),
    .p_tok       (p_tok)
  );

  assign xfer_c = SAMPLE_VLD & rdy_q;

  always_comb begin
    state_d     = state_q;
    ntaps_d     = ntaps_q;
    rem_d       = rem_q;
    symm_d      = symm_q;
    start_err_d = 1'b0;

    push_tok       = '0;
    push_tok.valid = xfer_c;
    push_tok.first = xfer_c & (rem_q == ntaps_q);
    push_tok.last  = xfer_c & (rem_q == TAPW'(1));

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (NTAPS == '0) begin
            start_err_d = 1'b1;
          end else begin
            ntaps_d = NTAPS;
            rem_d   = NTAPS;
            symm_d  = SYMM;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (xfer_c) begin
          rem_d = rem_q - TAPW'(1);
          if (rem_q == TAPW'(1)) state_d = ST_DRAIN;
        end
      end
      // Leave once the final tap's CEP edge is in the current cycle.
      ST_DRAIN: begin
        if (cep_q && p_last_q) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rdy_d    = (state_d == ST_ISSUE);
    busy_d   = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_FIN);
    cep_d    = p_tok.valid;
    p_last_d = p_tok.valid & p_tok.last;
    cectrl_d = early_tok_c.valid;
    opmode_d = early_tok_c.valid ? opmode_code(early_tok_c.first, symm_q) : opmode_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      ntaps_q     <= '0;
      rem_q       <= '0;
      symm_q      <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      opmode_q    <= '0;
      cectrl_q    <= 1'b0;
      cep_q       <= 1'b0;
      p_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ntaps_q     <= ntaps_d;
      rem_q       <= rem_d;
      symm_q      <= symm_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      opmode_q    <= opmode_d;
      cectrl_q    <= cectrl_d;
      cep_q       <= cep_d;
      p_last_q    <= p_last_d;
    end
  end

  assign SAMPLE_RDY = rdy_q;
  assign OPMODE     = opmode_q;
  assign CECTRL     = cectrl_q;
  assign CEIN       = busy_q;
  assign CEM        = busy_q;
  assign CEP        = cep_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign START_ERR  = start_err_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP slice (A/B, M, OPMODE, P regs).
`timescale 1ns/1ps
module tb_dsp_mac_sequencer;

  localparam int unsigned TAPW   = 8;
  localparam logic [6:0]  OP_ACC = 7'b0001001;
`ifdef DSP_SEQ_ROUND_EN
  localparam logic [6:0]  OP_FIRST = 7'b0001101;
  localparam logic [47:0] P_BASE   = 48'h40;
`else
  localparam logic [6:0]  OP_FIRST = 7'b0000001;
  localparam logic [47:0] P_BASE   = 48'h0;
`endif
  localparam logic [47:0] C_IN = 48'h40;

  logic            CLK = 1'b0;
  logic            RSTN = 1'b0;
  logic            START = 1'b0;
  logic [TAPW-1:0] NTAPS = '0;
  logic            SYMM = 1'b0;
  logic            SAMPLE_VLD = 1'b0;
  logic            SAMPLE_RDY, CECTRL, CEIN, CEM, CEP, BUSY, DONE, START_ERR;
  logic [6:0]      OPMODE;

  logic [17:0] a_in = '0;
  logic [17:0] b_in = '0;
  logic [17:0] a_r, b_r;
  logic [47:0] m_r, p_r;
  logic [6:0]  op_r;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_c = 0;
  int cep_base = 0;
  int op_base = 0;
  int done_rel = 0;
  int ce_acc = 0;
  int cep_log[$];
  logic [6:0] op_log[$];

  dsp_mac_sequencer #(.TAPW(TAPW), .PIPE_LAT(2)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .NTAPS(NTAPS), .SYMM(SYMM),
    .SAMPLE_VLD(SAMPLE_VLD), .SAMPLE_RDY(SAMPLE_RDY), .OPMODE(OPMODE),
    .CECTRL(CECTRL), .CEIN(CEIN), .CEM(CEM), .CEP(CEP), .BUSY(BUSY),
    .DONE(DONE), .START_ERR(START_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Slice model: operands -> A/B reg -> M reg -> P reg, OPMODE reg used at the P edge.
  always_ff @(posedge CLK) begin
    if (CEIN) begin
      a_r <= a_in;
      b_r <= b_in;
    end
    if (CEM) m_r <= 48'(a_r) * 48'(b_r);
    if (CECTRL) op_r <= OPMODE;
    if (CEP) p_r <= ((op_r[1:0] == 2'b01) ? m_r : 48'h0) +
                    ((op_r[3:2] == 2'b10) ? p_r : (op_r[3:2] == 2'b11) ? C_IN : 48'h0);
  end

  always @(negedge CLK) begin
    if (CEP) cep_log.push_back(cyc);
    if (CECTRL) op_log.push_back(OPMODE);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cep_rel(input int i);
    if (cep_base + i < cep_log.size()) return cep_log[cep_base+i] - start_c;
    return -1;
  endfunction

  function automatic logic [6:0] op_at(input int i);
    if (op_base + i < op_log.size()) return op_log[op_base+i];
    return 7'h7f;
  endfunction

  task automatic drive_job(input int n, input logic symm, input int a0, input int astep,
                           input int b0, input int stall_at, input int stall_len);
    int tap;
    int st;
    int guard;
    @(negedge CLK);
    start_c  = cyc;
    cep_base = cep_log.size();
    op_base  = op_log.size();
    START    = 1'b1;
    NTAPS    = TAPW'(n);
    SYMM     = symm;
    @(negedge CLK);
    START = 1'b0;
    tap = 0; st = 0; guard = 0;
    while (tap < n && guard < 300) begin
      guard++;
      if (tap == stall_at && st < stall_len && SAMPLE_RDY) begin
        SAMPLE_VLD = 1'b0;
        st++;
      end else begin
        SAMPLE_VLD = 1'b1;
        a_in = 18'(a0 + tap * astep);
        b_in = 18'(b0);
      end
      if (SAMPLE_VLD && SAMPLE_RDY) tap++;
      @(negedge CLK);
    end
    SAMPLE_VLD = 1'b0;
    if (tap != n) check("drive_taps", 64'(tap), 64'(n));
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!DONE && g < 60) begin
      @(negedge CLK);
      g++;
    end
    check("done_seen", 64'(DONE), 64'd1);
    done_rel = cyc - start_c;
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_outputs", 64'({SAMPLE_RDY, OPMODE, CECTRL, CEIN, CEM, CEP, BUSY, DONE, START_ERR}), 64'd0);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;

    // Four taps, no stalls, A*B=1
    drive_job(4, 1'b0, 1, 0, 1, -1, 0);
    wait_done();
    check("j1_done_lat", 64'(done_rel), 64'd7);
    check("j1_busy_at_done", 64'(BUSY), 64'd0);
    check("j1_p", 64'(p_r), 64'(P_BASE + 48'd4));
    check("j1_op_count", 64'(op_log.size() - op_base), 64'd4);
    check("j1_op0", 64'(op_at(0)), 64'(OP_FIRST));
    check("j1_op1", 64'(op_at(1)), 64'(OP_ACC));
    check("j1_op3", 64'(op_at(3)), 64'(OP_ACC));
    check("j1_cep_count", 64'(cep_log.size() - cep_base), 64'd4);
    check("j1_cep0", 64'(cep_rel(0)), 64'd3);
    check("j1_cep3", 64'(cep_rel(3)), 64'd6);

    // Three taps with a two-cycle gap after tap 1 (back-to-back start)
    drive_job(3, 1'b0, 2, 1, 3, 1, 2);
    wait_done();
    check("j2_done_lat", 64'(done_rel), 64'd8);
    check("j2_p", 64'(p_r), 64'(P_BASE + 48'd27));
    check("j2_cep0", 64'(cep_rel(0)), 64'd3);
    check("j2_cep1", 64'(cep_rel(1)), 64'd6);
    check("j2_cep2", 64'(cep_rel(2)), 64'd7);

    // START with zero taps
    @(negedge CLK);
    START = 1'b1;
    NTAPS = '0;
    @(negedge CLK);
    START = 1'b0;
    check("err_pulse", 64'(START_ERR), 64'd1);
    check("err_busy", 64'(BUSY), 64'd0);
    ce_acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      ce_acc += int'(CEIN | CEM | CEP | CECTRL | BUSY | SAMPLE_RDY);
    end
    check("err_no_activity", 64'(ce_acc), 64'd0);
    check("err_pulse_one_cycle", 64'(START_ERR), 64'd0);

    // Asynchronous reset while draining an 8-tap job
    drive_job(8, 1'b0, 1, 1, 2, -1, 0);
    check("rst_busy_before", 64'(BUSY), 64'd1);
    #1 RSTN = 1'b0;
    #1;
    check("rst_async_outputs", 64'({SAMPLE_RDY, OPMODE, CECTRL, CEIN, CEM, CEP, BUSY, DONE, START_ERR}), 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    drive_job(2, 1'b0, 3, 0, 4, -1, 0);
    wait_done();
    check("post_rst_done_lat", 64'(done_rel), 64'd5);
    check("post_rst_p", 64'(p_r), 64'(P_BASE + 48'd24));
    check("post_rst_cep_count", 64'(cep_log.size() - cep_base), 64'd2);

    // Symmetric mode sets the pre-adder bit on both codes
    drive_job(2, 1'b1, 1, 0, 1, -1, 0);
    wait_done();
    check("symm_op0", 64'(op_at(0)), 64'(OP_FIRST | 7'b0010000));
    check("symm_op1", 64'(op_at(1)), 64'(OP_ACC | 7'b0010000));

    // Single tap, A*B=5; START during FIN must be ignored
    drive_job(1, 1'b0, 5, 0, 1, -1, 0);
    wait_done();
    START = 1'b1;
    NTAPS = TAPW'(3);
    check("one_tap_done_lat", 64'(done_rel), 64'd4);
    check("one_tap_op0", 64'(op_at(0)), 64'(OP_FIRST));
    check("one_tap_p", 64'(p_r), 64'(P_BASE + 48'd5));
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    check("fin_start_ignored", 64'({BUSY, SAMPLE_RDY}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
